// File: rtl/spi_minion_pkg.sv
// Shared types and pin levels for the SPI mode-0 minion endpoint.
package spi_minion_pkg;

  // Frame FSM: idle between chip-select assertions, active while cs is low.
  typedef enum logic {
    STATE_IDLE   = 1'b0,
    STATE_ACTIVE = 1'b1
  } state_t;

  // Idle pin levels. These are also the synchronizer reset values, so the
  // edge detectors report no edges while the pins sit idle.
  localparam logic CS_INACTIVE = 1'b1;
  localparam logic SCLK_IDLE   = 1'b0;

endpackage

// File: rtl/spi_minion_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus a history flop.
// Rise and fall are decoded from the last two synchronized samples. They are
// combinational on the synchronized level and history. A pin edge is therefore
// acted on at the (nsync+1)th clk posedge after it is first sampled.
module spi_minion_sync_edge #(
  parameter int   nsync   = 2,
  parameter logic rst_val = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [nsync-1:0] sync_q;
  logic             hist_q;

  // Shift the raw pin through the synchronizer chain and keep one sample of history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= {nsync{rst_val}};
      hist_q <= rst_val;
    end else begin
      sync_q <= {sync_q[nsync-2:0], din};
      hist_q <= sync_q[nsync-1];
    end
  end

  assign level = sync_q[nsync-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_minion_val_rdy.sv
// SPI mode-0 minion endpoint. It oversamples cs/sclk/mosi on clk and shifts
// one full-duplex nbits frame per chip-select assertion.
//
// Handshakes (recv_* and send_*): a transfer happens on a clk posedge where
// val and rdy are both high. val never depends on rdy. Once the minion raises
// send_val, it holds it and keeps send_msg stable until the transfer.
//
// recv side: one-word transmit buffer. It is emptied into the output shift
// register when the frame starts.
// send side: one-word receive buffer. It is loaded when a frame with exactly
// nbits sclk rises completes.
module spi_minion_val_rdy
  import spi_minion_pkg::*;
#(
  parameter int nbits = 34,
  parameter int nsync = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_ifc_cs,
  input  logic             spi_ifc_sclk,
  input  logic             spi_ifc_mosi,
  output logic             spi_ifc_miso,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             overflow,
  output logic             frame_err,
  output logic             state_dbg
);

  localparam int                CNT_W    = $clog2(nbits + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(nbits);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(nbits + 1);

  state_t state_q, state_d;

  logic cs_level, cs_rise, cs_fall;
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  logic             armed;
  logic [nsync-1:0] flush_q;
  logic             sync_flushed;
  logic [CNT_W-1:0] bit_cnt;
  logic [nbits-1:0] shreg_in;
  logic [nbits-1:0] shreg_out;
  logic [nbits-1:0] tx_buf;
  logic             tx_full;
  logic [nbits-1:0] rx_buf;
  logic             rx_full;

  logic frame_start;
  logic frame_end;
  logic frame_complete;
  logic send_fire;

  spi_minion_sync_edge #(.nsync(nsync), .rst_val(CS_INACTIVE)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .din   (spi_ifc_cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_minion_sync_edge #(.nsync(nsync), .rst_val(SCLK_IDLE)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (spi_ifc_sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_minion_sync_edge #(.nsync(nsync), .rst_val(1'b0)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .din   (spi_ifc_mosi),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  assign frame_start    = (state_q == STATE_IDLE) && cs_fall && armed;
  assign frame_end      = (state_q == STATE_ACTIVE) && cs_rise;
  assign frame_complete = frame_end && (bit_cnt == CNT_FULL);
  assign send_fire      = send_val && send_rdy;
  assign sync_flushed   = flush_q[nsync-1];

  assign recv_rdy     = !tx_full;
  assign send_val     = rx_full;
  assign send_msg     = rx_buf;
  assign spi_ifc_miso = (state_q == STATE_ACTIVE) ? shreg_out[nbits-1] : 1'b0;
  assign state_dbg    = (state_q == STATE_ACTIVE);

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= STATE_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a frame opens on an armed cs fall and closes on cs rise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_IDLE:   if (frame_start) state_d = STATE_ACTIVE;
      STATE_ACTIVE: if (cs_rise)     state_d = STATE_IDLE;
      default:      state_d = STATE_IDLE;
    endcase
  end

  // Arm only after cs has been seen high. The synchronizer resets to the
  // inactive level, so samples are trusted only once the chain has flushed.
  // This keeps a transaction already in flight at reset release from being
  // picked up halfway.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flush_q <= '0;
      armed   <= 1'b0;
    end else begin
      flush_q <= {flush_q[nsync-2:0], 1'b1};
      if (sync_flushed && (cs_level == CS_INACTIVE)) armed <= 1'b1;
    end
  end

  // Transmit buffer: the frame start drains it, then a recv handshake refills it.
  // A word offered on the frame-start cycle is judged against the registered
  // tx_full. If accepted, it waits for the next frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else begin
      if (frame_start) tx_full <= 1'b0;
      if (recv_val && recv_rdy) begin
        tx_buf  <= recv_msg;
        tx_full <= 1'b1;
      end
    end
  end

  // Shift registers and bit counter. mosi is captured on sclk rise, and miso
  // advances on sclk fall. The counter saturates so that overlong frames
  // cannot wrap back onto nbits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_in  <= '0;
      shreg_out <= '0;
      bit_cnt   <= '0;
    end else if (frame_start) begin
      shreg_out <= tx_full ? tx_buf : '0;
      shreg_in  <= '0;
      bit_cnt   <= '0;
    end else if (state_q == STATE_ACTIVE) begin
      if (sclk_rise) begin
        shreg_in <= {shreg_in[nbits-2:0], mosi_level};
        if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
      end
      if (sclk_fall) shreg_out <= {shreg_out[nbits-2:0], 1'b0};
    end
  end

  // Receive buffer and status pulses. A completed frame loads the buffer if it
  // is empty or is being handed off this same cycle. Otherwise the frame is
  // dropped and overflow is flagged. Short or overlong frames raise frame_err.
  // A frame with no sclk at all is dropped silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_buf    <= '0;
      rx_full   <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      if (send_fire) rx_full <= 1'b0;
      if (frame_complete) begin
        if (!rx_full || send_fire) begin
          rx_buf  <= shreg_in;
          rx_full <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (frame_end && (bit_cnt != '0)) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_minion_val_rdy.sv
// Directed bench for spi_minion_val_rdy with nbits=8 and nsync=2.
// The SPI master is modelled by tasks. Every sclk phase and the cs setup time
// last 6 clk cycles.
module tb_spi_minion_val_rdy;

  localparam int NB = 8;
  localparam int PH = 6;

  logic          clk;
  logic          reset;
  logic          cs, sclk, mosi, miso;
  logic          recv_val, recv_rdy;
  logic [NB-1:0] recv_msg;
  logic          send_val, send_rdy;
  logic [NB-1:0] send_msg;
  logic          overflow, frame_err, state_dbg;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  logic [NB-1:0] exp_q[$];

  spi_minion_val_rdy #(.nbits(NB), .nsync(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_ifc_cs   (cs),
    .spi_ifc_sclk (sclk),
    .spi_ifc_mosi (mosi),
    .spi_ifc_miso (miso),
    .recv_val     (recv_val),
    .recv_rdy     (recv_rdy),
    .recv_msg     (recv_msg),
    .send_val     (send_val),
    .send_rdy     (send_rdy),
    .send_msg     (send_msg),
    .overflow     (overflow),
    .frame_err    (frame_err),
    .state_dbg    (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every send handshake must match the next expected word.
  // Status pulses are counted so their totals can be compared.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) ferr_cnt++;
      if (overflow)  ovf_cnt++;
      if (send_val && send_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL unexpected_handshake: observed %h expected none", send_msg);
        end else begin
          logic [NB-1:0] e;
          e = exp_q.pop_front();
          assert (send_msg === e) else begin
            errors++;
            $error("FAIL handshake_msg: observed %h expected %h", send_msg, e);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NB-1:0] w);
    recv_val = 1'b1;
    recv_msg = w;
    tick(1);
    recv_val = 1'b0;
  endtask

  task automatic consume(input logic [NB-1:0] w);
    exp_q.push_back(w);
    send_rdy = 1'b1;
    tick(1);
    send_rdy = 1'b0;
  endtask

  // n sclk pulses. mosi is set at the start of each low phase, and miso is
  // sampled just before each rise.
  task automatic shift_bits(input logic [NB-1:0] data, input int n, output logic [NB-1:0] mb);
    mb = '0;
    for (int i = 0; i < n; i++) begin
      mosi = (i < NB) ? data[NB-1-i] : 1'b0;
      tick(PH);
      if (i < NB) mb[NB-1-i] = miso;
      sclk = 1'b1;
      tick(PH);
      sclk = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [NB-1:0] data, input int n, output logic [NB-1:0] mb);
    cs = 1'b0;
    shift_bits(data, n, mb);
    tick(PH);
    cs = 1'b1;
    tick(PH);
  endtask

  logic [NB-1:0] mb;
  int f0, o0;

  initial begin
    reset = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    recv_val = 1'b0; recv_msg = '0; send_rdy = 1'b0;
    tick(3);
    check("rst_recv_rdy", recv_rdy, 1);
    check("rst_send_val", send_val, 0);
    check("rst_send_msg", send_msg, 0);
    check("rst_miso", miso, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b1;
    tick(5);

    // Frame with a loaded transmit word. Check the cs-fall and cs-rise latencies.
    push(8'hA5);
    check("t1_rdy_after_push", recv_rdy, 0);
    cs = 1'b0;
    tick(2);
    check("t1_rdy_before_fall", recv_rdy, 0);
    check("t1_idle_before_fall", state_dbg, 0);
    tick(1);
    check("t1_rdy_at_fall", recv_rdy, 1);
    check("t1_active", state_dbg, 1);
    check("t1_first_miso", miso, 1);
    tick(3);
    shift_bits(8'h3C, 8, mb);
    tick(PH);
    cs = 1'b1;
    tick(2);
    check("t1_val_before_rise", send_val, 0);
    tick(1);
    check("t1_val_after_rise", send_val, 1);
    check("t1_msg", send_msg, 8'h3C);
    check("t1_miso_bits", mb, 8'hA5);
    check("t1_idle", state_dbg, 0);
    check("t1_miso_idle", miso, 0);
    consume(8'h3C);
    check("t1_val_dropped", send_val, 0);

    // Frame with the transmit buffer empty: miso stays 0.
    do_frame(8'h96, 8, mb);
    check("t2_miso_bits", mb, 8'h00);
    check("t2_val", send_val, 1);
    check("t2_msg", send_msg, 8'h96);
    consume(8'h96);

    // Two frames with no consumer: the second is dropped with one overflow pulse.
    o0 = ovf_cnt;
    do_frame(8'h11, 8, mb);
    check("t3_msg_first", send_msg, 8'h11);
    cs = 1'b0;
    shift_bits(8'h22, 8, mb);
    tick(PH);
    cs = 1'b1;
    tick(2);
    check("t3_ovf_before", overflow, 0);
    tick(1);
    check("t3_ovf_pulse", overflow, 1);
    tick(1);
    check("t3_ovf_after", overflow, 0);
    check("t3_ovf_count", ovf_cnt - o0, 1);
    check("t3_msg_kept", send_msg, 8'h11);
    consume(8'h11);
    check("t3_val_dropped", send_val, 0);

    // Short frame of 5 sclk rises raises frame_err.
    cs = 1'b0;
    shift_bits(8'hF0, 5, mb);
    tick(PH);
    cs = 1'b1;
    tick(2);
    check("t4_ferr_before", frame_err, 0);
    tick(1);
    check("t4_ferr_pulse", frame_err, 1);
    tick(1);
    check("t4_ferr_after", frame_err, 0);
    check("t4_val", send_val, 0);

    // An overlong frame (9 rises) is also an error.
    f0 = ferr_cnt;
    do_frame(8'h0F, 9, mb);
    check("t4_long_ferr", ferr_cnt - f0, 1);
    check("t4_long_val", send_val, 0);

    // A cs pulse with no sclk raises no flags.
    f0 = ferr_cnt; o0 = ovf_cnt;
    do_frame(8'h00, 0, mb);
    check("t4_empty_ferr", ferr_cnt - f0, 0);
    check("t4_empty_ovf", ovf_cnt - o0, 0);
    check("t4_empty_val", send_val, 0);

    // Reset released while cs is still low mid-frame: no frame is picked up.
    f0 = ferr_cnt;
    cs = 1'b0;
    shift_bits(8'hC3, 2, mb);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(4);
    check("t5_idle_after_reset", state_dbg, 0);
    shift_bits(8'hC3, 6, mb);
    tick(PH);
    cs = 1'b1;
    tick(PH);
    check("t5_no_frame", send_val, 0);
    check("t5_no_ferr", ferr_cnt - f0, 0);
    do_frame(8'h5A, 8, mb);
    check("t5_val", send_val, 1);
    check("t5_msg", send_msg, 8'h5A);
    consume(8'h5A);

    // A frame completes on the same cycle as a send handshake: no overflow.
    o0 = ovf_cnt;
    do_frame(8'h77, 8, mb);
    check("t6_msg_old", send_msg, 8'h77);
    cs = 1'b0;
    shift_bits(8'h88, 8, mb);
    tick(PH);
    cs = 1'b1;
    tick(2);
    exp_q.push_back(8'h77);
    send_rdy = 1'b1;
    tick(1);
    send_rdy = 1'b0;
    check("t6_val", send_val, 1);
    check("t6_msg_new", send_msg, 8'h88);
    tick(2);
    check("t6_no_ovf", ovf_cnt - o0, 0);
    consume(8'h88);
    check("t6_val_dropped", send_val, 0);

    tick(2);
    check("sb_drained", exp_q.size(), 0);

    // Report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_minion_val_rdy.md
Name: spi_minion_val_rdy

Overview:
SPI mode-0 minion (peripheral) endpoint. It is the far end of the team's SPI master block. It oversamples the external cs/sclk/mosi pins on the system clock and shifts one fixed-length full-duplex frame per chip-select assertion. Received words go out on a val/rdy send interface. Words to return on miso are taken from a val/rdy recv interface. It sits at the chip pad boundary, between the SPI pins and the on-chip message network.

Parameters:
nbits, 34, frame length in bits; width of recv_msg and send_msg
nsync, 2, synchronizer depth (flops) on each SPI input pin; minimum 2

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-low reset (reset==0 resets on the next posedge)
spi_ifc_cs  input  1  chip select from master, active low, asynchronous to clk
spi_ifc_sclk  input  1  SPI clock from master, idle low, asynchronous
spi_ifc_mosi  input  1  serial data from master, asynchronous
spi_ifc_miso  output  1  serial data to master
recv_val  input  1  word to transmit next frame is valid
recv_rdy  output  1  transmit buffer empty
recv_msg  input  nbits  word to transmit, MSB first
send_val  output  1  received word valid
send_rdy  input  1  consumer accepts received word
send_msg  output  nbits  received word; first bit received is the MSB
overflow  output  1  one-cycle pulse: completed frame dropped because send buffer was full
frame_err  output  1  one-cycle pulse: cs rose after 1..nbits-1 or more than nbits sclk rising edges

Behaviour:
- Reset values: miso=0, recv_rdy=1, send_val=0, send_msg=0, overflow=0, frame_err=0, FSM=IDLE, armed=0, bit_cnt=0, all shift registers 0. Synchronizer reset values: cs=1, sclk=0, mosi=0.
- Each pin passes through nsync flops plus one history flop. Edge detect uses the last two synchronized samples.
- Edge latency: an edge on a pin is detected on the (nsync+1)th clk posedge after it is first sampled.
- Master timing requirement: each sclk phase is ≥ nsync+2 clk cycles, and cs-fall to first sclk rise is ≥ nsync+2 cycles. Behaviour outside this constraint is undefined.
- armed: set when synchronized cs is high; cleared by reset. This prevents starting a frame in the middle of a transaction already in progress when reset is released.
- Transmit buffer:
  - Holds one word, tracked by flag tx_full. recv_rdy = !tx_full.
  - recv_val & recv_rdy loads tx_buf and sets tx_full.
- Receive buffer:
  - Holds one word. send_val = rx_full. send_msg = rx_buf.
  - send_val & send_rdy clears rx_full.
- FSM, states IDLE and ACTIVE:
  - IDLE -> ACTIVE on cs_fall & armed. On that cycle:
    - shreg_out <= tx_full ? tx_buf : 0
    - tx_full cleared
    - bit_cnt <= 0; shreg_in <= 0
  - If recv_val arrives in the same cycle as cs_fall, the word is sampled against the registered tx_full. When the buffer is empty, the word is accepted into tx_buf and goes out in the next frame, not this one.
  - ACTIVE, sclk_rise: shreg_in <= {shreg_in[nbits-2:0], mosi_sync}; bit_cnt increments, saturating at nbits+1.
  - ACTIVE, sclk_fall: shreg_out shifts left, filling with 0.
  - ACTIVE -> IDLE on cs_rise:
    - bit_cnt==nbits and !rx_full, or rx_full cleared this same cycle by a send handshake: rx_buf <= shreg_in, rx_full set. send_val goes high on the next cycle.
    - bit_cnt==nbits and rx_full held: word dropped, overflow pulses, rx_buf unchanged.
    - bit_cnt==0: frame silently discarded.
    - Any other bit_cnt: frame discarded, frame_err pulses.
- miso = shreg_out[nbits-1] while the FSM is ACTIVE, otherwise 0. The first bit is therefore valid before the first sclk rise, as mode 0 requires.
- sclk and mosi edges are ignored in IDLE.
- bit_cnt is $clog2(nbits+2) bits wide.
- Reset asserted mid-frame: all state returns to reset values. The next frame starts only after cs has been seen high.

Decomposition:
- Package spi_minion_pkg:
  - state_t enum {STATE_IDLE, STATE_ACTIVE}, 1 bit
  - localparams: cs-inactive level 1'b1, sclk idle level 1'b0
- Sub-module spi_minion_sync_edge:
  - one nsync-deep synchronizer plus history flop
  - outputs: synced level, rise pulse, fall pulse
  - reset-value parameter
  - instantiated once each for cs, sclk and mosi (mosi uses only the level output)
- Shift registers and buffers are inline.

Test Plan:
- nbits=8. Push recv_msg=8'hA5. Drive a frame (sclk phase 6 clk) with mosi 8'h3C. -> miso shows bits 1,0,1,0,0,1,0,1; send_msg=8'h3C, send_val=1 the cycle after cs_rise is detected; recv_rdy returns to 1 at cs_fall.
- Frame with the transmit buffer empty -> miso constant 0; frame still received normally.
- Two back-to-back frames (8'h11, 8'h22) with send_rdy=0 -> send_msg stays 8'h11, overflow pulses once at the second cs_rise. Then send_rdy=1 -> handshake, send_val drops.
- Frame of 5 sclk edges -> frame_err one-cycle pulse, send_val stays 0. A cs pulse with no sclk -> no flags raised.
- Deassert reset while cs is held low mid-frame -> no frame accepted. After cs rises and a full 8'h5A frame follows, send_msg=8'h5A.
- Completed frame coincides with send_val&send_rdy in the same cycle -> old word handed off, new word loaded, overflow stays 0.
